// File: rtl/instcycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// instcycle_ctrl_if
// Bundles the sequencer's bus handshakes, core control inputs and status
// outputs. clk/rst stay outside the bundle as plain module ports.
//
// Handshake rules (both buses):
//   A request (if_req_o / mem_req_o) stays high until the matching ready
//   (if_ready_i / mem_ready_i) is sampled high at a rising edge. That edge
//   completes the transfer. A ready that arrives while its request is low
//   is ignored.
//
// Modports:
//   master - the sequencer: drives requests, stage counter and status
//   slave  - the bus/core side: drives readies, mem_access_i and halt_i
// ----------------------------------------------------------------------------
interface instcycle_ctrl_if;
   logic        if_ready_i;
   logic        mem_access_i;
   logic        mem_ready_i;
   logic        halt_i;
   logic [7:0]  instcycle_cnt_val;
   logic        if_req_o;
   logic        mem_req_o;
   logic        commit_o;
   logic [63:0] instret_o;
   logic        timeout_o;

   modport master (
      input  if_ready_i, mem_access_i, mem_ready_i, halt_i,
      output instcycle_cnt_val, if_req_o, mem_req_o, commit_o, instret_o,
             timeout_o
   );

   modport slave (
      output if_ready_i, mem_access_i, mem_ready_i, halt_i,
      input  instcycle_cnt_val, if_req_o, mem_req_o, commit_o, instret_o,
             timeout_o
   );
endinterface

// File: rtl/instcycle_ctrl.sv
// ----------------------------------------------------------------------------
// instcycle_ctrl
// Multi-cycle instruction sequencer for the non-pipelined core. The 8-bit
// stage counter (0=IF 1=ID 2=EX 3=MEM 4=WB) is the FSM state itself and is
// exported directly as instcycle_cnt_val. The block owns the fetch and data
// bus request/ready handshakes, skips MEM waits for non-memory instructions,
// counts retired instructions, and aborts bus waits that exceed TIMEOUT.
//
// Parameters:
//   TIMEOUT - wait cycles allowed in IF or MEM before abort (0 = disabled)
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - instcycle_ctrl_if.master: readies, mem_access_i, halt_i in;
//         stage counter, requests, commit, instret, timeout out
// ----------------------------------------------------------------------------
module instcycle_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   instcycle_ctrl_if.master  bus
);

   typedef enum logic [7:0] {
      ST_IF  = 8'd0,
      ST_ID  = 8'd1,
      ST_EX  = 8'd2,
      ST_MEM = 8'd3,
      ST_WB  = 8'd4
   } state_t;

   localparam logic [7:0] TIMEOUT_V  = TIMEOUT[7:0];
   localparam logic       TIMEOUT_EN = (TIMEOUT != 0);

   // Kept as a plain 8-bit register so that out-of-range values can exist
   // (e.g. after an upset) and be steered back to IF by the default arm.
   logic [7:0]  state_q;
   logic [7:0]  state_nxt;
   logic [7:0]  wait_q;
   logic [7:0]  wait_nxt;
   logic [63:0] instret_q;
   logic        timeout_q;
   logic        retire;
   logic        abort;
   logic [7:0]  wait_inc;

   // Saturate so a disabled timeout never lets the count wrap back to 0.
   assign wait_inc = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IF;
         wait_q    <= 8'd0;
         instret_q <= 64'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         wait_q  <= wait_nxt;
         if (retire) begin
            instret_q <= instret_q + 64'd1;
         end
         if (abort) begin
            timeout_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next state, wait counter, retire/abort strobes
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state_q;
      wait_nxt  = 8'd0;
      retire    = 1'b0;
      abort     = 1'b0;
      case (state_q)
         ST_IF: begin
            if (bus.halt_i) begin
               state_nxt = ST_IF;
            end else if (bus.if_ready_i) begin
               // Ready beats a timeout falling on the same edge.
               state_nxt = ST_ID;
            end else if (TIMEOUT_EN && (wait_q == TIMEOUT_V)) begin
               abort     = 1'b1;
               state_nxt = ST_IF;
            end else begin
               wait_nxt  = wait_inc;
            end
         end
         ST_ID: begin
            state_nxt = ST_EX;
         end
         ST_EX: begin
            state_nxt = ST_MEM;
         end
         ST_MEM: begin
            if (!bus.mem_access_i || bus.mem_ready_i) begin
               state_nxt = ST_WB;
            end else if (TIMEOUT_EN && (wait_q == TIMEOUT_V)) begin
               abort     = 1'b1;
               state_nxt = ST_IF;
            end else begin
               wait_nxt  = wait_inc;
            end
         end
         ST_WB: begin
            retire    = 1'b1;
            state_nxt = ST_IF;
         end
         default: begin
            state_nxt = ST_IF;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs: requests and commit are combinational and forced low in reset
   // so an in-flight transaction is dropped in the very cycle rst rises.
   // ------------------------------------------------------------------------
   assign bus.if_req_o          = !rst && (state_q == ST_IF) && !bus.halt_i;
   assign bus.mem_req_o         = !rst && (state_q == ST_MEM) && bus.mem_access_i;
   assign bus.commit_o          = !rst && (state_q == ST_WB);
   assign bus.instcycle_cnt_val = state_q;
   assign bus.instret_o         = instret_q;
   assign bus.timeout_o         = timeout_q;

endmodule

// File: tb/tb_instcycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_instcycle_ctrl
// Directed bench for instcycle_ctrl with TIMEOUT=4. A cycle-by-cycle table of
// inputs and hand-computed outputs walks through free run, IF wait, load
// wait, halt, MEM timeout (with and without ready on the timeout edge),
// reset mid-MEM / mid-WB and an IF timeout. Hand-written sequences then
// measure instruction latency for several wait combinations.
// ----------------------------------------------------------------------------
module tb_instcycle_ctrl;

   logic clk;
   logic rst;

   instcycle_ctrl_if bus ();

   instcycle_ctrl #(.TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ------------------------------------------------------------------------
   // Clock
   // ------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Vector table
   // ------------------------------------------------------------------------
   typedef struct {
      logic        r;
      logic        ir;
      logic        ma;
      logic        mr;
      logic        h;
      logic [7:0]  cnt;
      logic        ifq;
      logic        mq;
      logic        cm;
      logic [63:0] inst;
      logic        to;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic v(input logic r, input logic ir, input logic ma,
                    input logic mr, input logic h, input logic [7:0] cnt,
                    input logic ifq, input logic mq, input logic cm,
                    input logic [63:0] inst, input logic to);
      vec_t e;
      e.r = r; e.ir = ir; e.ma = ma; e.mr = mr; e.h = h;
      e.cnt = cnt; e.ifq = ifq; e.mq = mq; e.cm = cm; e.inst = inst; e.to = to;
      vecs.push_back(e);
   endtask

   task automatic check(input string name, input int row,
                        input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic ir, input logic ma,
                        input logic mr, input logic h);
      rst             = r;
      bus.if_ready_i   = ir;
      bus.mem_access_i = ma;
      bus.mem_ready_i  = mr;
      bus.halt_i       = h;
   endtask

   // One instruction started from IF; if_ready rises after ifw cycles and
   // mem_ready after memw MEM cycles. Counts cycles up to and including the
   // commit cycle, bounded by a cycle budget.
   task automatic run_instr(input int ifw, input int memw, input logic ma,
                            input int exp_lat, input int tag);
      int  cyc;
      bit  done;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         drive(1'b0, (cyc >= ifw), ma, (cyc >= ifw + 3 + memw), 1'b0);
         #1;
         cyc++;
         if (bus.commit_o === 1'b1) done = 1'b1;
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL latency_budget seq %0d: no commit within %0d cycles", tag, cyc);
      end else if (cyc != exp_lat) begin
         n_err++;
         $display("FAIL latency seq %0d: got %0d expected %0d", tag, cyc, exp_lat);
      end
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      //  r ir ma mr h   cnt ifq mq cm inst to
      // reset state
      v(1,0,0,0,0, 0,0,0,0,0,0);
      // free run: three instructions back to back
      v(0,1,0,0,0, 0,1,0,0,0,0);
      v(0,1,0,0,0, 1,0,0,0,0,0);
      v(0,1,0,0,0, 2,0,0,0,0,0);
      v(0,1,0,0,0, 3,0,0,0,0,0);
      v(0,1,0,0,0, 4,0,0,1,0,0);
      v(0,1,0,0,0, 0,1,0,0,1,0);
      v(0,1,0,0,0, 1,0,0,0,1,0);
      v(0,1,0,0,0, 2,0,0,0,1,0);
      v(0,1,0,0,0, 3,0,0,0,1,0);
      v(0,1,0,0,0, 4,0,0,1,1,0);
      v(0,1,0,0,0, 0,1,0,0,2,0);
      v(0,1,0,0,0, 1,0,0,0,2,0);
      v(0,1,0,0,0, 2,0,0,0,2,0);
      v(0,1,0,0,0, 3,0,0,0,2,0);
      v(0,1,0,0,0, 4,0,0,1,2,0);
      // IF wait: ready on the 4th IF cycle, commit in cycle 8
      v(0,0,0,0,0, 0,1,0,0,3,0);
      v(0,0,0,0,0, 0,1,0,0,3,0);
      v(0,0,0,0,0, 0,1,0,0,3,0);
      v(0,1,0,0,0, 0,1,0,0,3,0);
      v(0,1,0,0,0, 1,0,0,0,3,0);
      v(0,1,0,0,0, 2,0,0,0,3,0);
      v(0,1,0,0,0, 3,0,0,0,3,0);
      v(0,1,0,0,0, 4,0,0,1,3,0);
      // load wait: mem_ready on the 3rd MEM cycle
      v(0,1,0,0,0, 0,1,0,0,4,0);
      v(0,1,1,0,0, 1,0,0,0,4,0);
      v(0,1,1,0,0, 2,0,0,0,4,0);
      v(0,0,1,0,0, 3,0,1,0,4,0);
      v(0,0,1,0,0, 3,0,1,0,4,0);
      v(0,0,1,1,0, 3,0,1,0,4,0);
      v(0,0,1,0,0, 4,0,0,1,4,0);
      // halt raised in EX: instruction still commits, then IF is held
      v(0,1,0,0,0, 0,1,0,0,5,0);
      v(0,1,0,0,0, 1,0,0,0,5,0);
      v(0,1,0,0,1, 2,0,0,0,5,0);
      v(0,1,0,0,1, 3,0,0,0,5,0);
      v(0,1,0,0,1, 4,0,0,1,5,0);
      v(0,1,0,0,1, 0,0,0,0,6,0);
      v(0,1,0,0,1, 0,0,0,0,6,0);
      v(0,0,0,0,0, 0,1,0,0,6,0);
      v(0,1,0,0,0, 0,1,0,0,6,0);
      // MEM timeout: wait count reaches 4 without ready -> abort to IF
      v(0,1,0,0,0, 1,0,0,0,6,0);
      v(0,1,0,0,0, 2,0,0,0,6,0);
      v(0,0,1,0,0, 3,0,1,0,6,0);
      v(0,0,1,0,0, 3,0,1,0,6,0);
      v(0,0,1,0,0, 3,0,1,0,6,0);
      v(0,0,1,0,0, 3,0,1,0,6,0);
      v(0,0,1,0,0, 3,0,1,0,6,0);
      v(0,1,0,0,0, 0,1,0,0,6,1);
      // ready on the timeout edge wins
      v(0,1,0,0,0, 1,0,0,0,6,1);
      v(0,1,0,0,0, 2,0,0,0,6,1);
      v(0,0,1,0,0, 3,0,1,0,6,1);
      v(0,0,1,0,0, 3,0,1,0,6,1);
      v(0,0,1,0,0, 3,0,1,0,6,1);
      v(0,0,1,0,0, 3,0,1,0,6,1);
      v(0,0,1,1,0, 3,0,1,0,6,1);
      v(0,0,1,0,0, 4,0,0,1,6,1);
      // reset while waiting in MEM with instret=7
      v(0,1,0,0,0, 0,1,0,0,7,1);
      v(0,1,0,0,0, 1,0,0,0,7,1);
      v(0,1,0,0,0, 2,0,0,0,7,1);
      v(0,0,1,0,0, 3,0,1,0,7,1);
      v(1,0,1,0,0, 3,0,0,0,7,1);
      v(0,0,0,0,0, 0,1,0,0,0,0);
      // reset during WB: no commit, no increment
      v(0,1,0,0,0, 0,1,0,0,0,0);
      v(0,1,0,0,0, 1,0,0,0,0,0);
      v(0,1,0,0,0, 2,0,0,0,0,0);
      v(0,1,0,0,0, 3,0,0,0,0,0);
      v(1,0,0,0,0, 4,0,0,0,0,0);
      // reset in IF drops if_req; then IF timeout after 4 waits
      v(0,0,0,0,0, 0,1,0,0,0,0);
      v(1,0,0,0,0, 0,0,0,0,0,0);
      v(0,0,0,0,0, 0,1,0,0,0,0);
      v(0,0,0,0,0, 0,1,0,0,0,0);
      v(0,0,0,0,0, 0,1,0,0,0,0);
      v(0,0,0,0,0, 0,1,0,0,0,0);
      v(0,0,0,0,0, 0,1,0,0,0,0);
      v(0,0,0,0,1, 0,0,0,0,0,1);

      // reset prologue
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].r, vecs[i].ir, vecs[i].ma, vecs[i].mr, vecs[i].h);
         #1;
         check("cnt",     i, 64'(bus.instcycle_cnt_val), 64'(vecs[i].cnt));
         check("if_req",  i, 64'(bus.if_req_o),          64'(vecs[i].ifq));
         check("mem_req", i, 64'(bus.mem_req_o),         64'(vecs[i].mq));
         check("commit",  i, 64'(bus.commit_o),          64'(vecs[i].cm));
         check("instret", i, bus.instret_o,              vecs[i].inst);
         check("timeout", i, 64'(bus.timeout_o),         64'(vecs[i].to));
      end

      // latency sequences: 5 + IF waits + MEM waits
      run_instr(0, 0, 1'b0, 5, 0);
      run_instr(2, 0, 1'b0, 7, 1);
      run_instr(0, 2, 1'b1, 7, 2);
      run_instr(1, 3, 1'b1, 9, 3);

      @(negedge clk);
      #1;
      check("instret_after_seq", vecs.size(), bus.instret_o, 64'd4);
      check("cnt_after_seq",     vecs.size(), 64'(bus.instcycle_cnt_val), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
